// File: rtl/clock_mode_ctrl.sv
// Wall-clock mode controller: keeps hh:mm:ss, sequences RUN / SET_HH / SET_MM
// on button pulses with an idle timeout, and drives the digit-blanking flags.
module clock_mode_ctrl #(
    parameter int TICK_MAX  = 100000000,
    parameter int TIMEOUT_S = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       blink,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic [1:0] mode,
    output logic       hide_hh,
    output logic       hide_mm,
    output logic       sec_tick
);

    localparam int PRESC_W = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
    localparam int IDLE_W  = ($clog2(TIMEOUT_S + 1) > 4) ? $clog2(TIMEOUT_S + 1) : 4;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_MAX - 1);
    localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(TIMEOUT_S - 1);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_SET_HH = 2'd1;
    localparam logic [1:0] ST_SET_MM = 2'd2;

    logic [1:0]         r_state;
    logic [PRESC_W-1:0] r_presc;
    logic [IDLE_W-1:0]  r_idle;
    logic [4:0]         r_hours;
    logic [5:0]         r_minutes;
    logic [5:0]         r_seconds;
    logic               r_hide_hh;
    logic               r_hide_mm;
    logic               r_sec_tick;

    logic       w_tick;
    logic       w_btn_any;
    logic       w_inc_ok;
    logic       w_timeout;
    logic       w_exit_set;
    logic [1:0] w_state_nxt;

    function automatic logic [4:0] inc_mod24(input logic [4:0] v);
        return (v == 5'd23) ? 5'd0 : v + 5'd1;
    endfunction

    function automatic logic [5:0] inc_mod60(input logic [5:0] v);
        return (v == 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    assign w_tick    = (r_presc == PRESC_LAST);
    assign w_btn_any = btn_mode | btn_inc;
    // btn_mode takes priority over btn_inc in the same cycle
    assign w_inc_ok  = btn_inc & ~btn_mode;
    // A button pulse in the timeout cycle keeps the user in the set state
    assign w_timeout = (r_state != ST_RUN) && w_tick && (r_idle == IDLE_LAST) && !w_btn_any;

    always_comb begin
        w_state_nxt = r_state;
        w_exit_set  = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (btn_mode) begin
                    w_state_nxt = ST_SET_HH;
                end
            end
            ST_SET_HH: begin
                if (btn_mode) begin
                    w_state_nxt = ST_SET_MM;
                end else if (w_timeout) begin
                    w_state_nxt = ST_RUN;
                    w_exit_set  = 1'b1;
                end
            end
            ST_SET_MM: begin
                if (btn_mode || w_timeout) begin
                    w_state_nxt = ST_RUN;
                    w_exit_set  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Leaving a set state restarts the second so the first one is full length
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_presc <= '0;
        end else if (w_exit_set || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PRESC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idle <= '0;
        end else if (r_state == ST_RUN || w_btn_any || w_state_nxt != r_state) begin
            r_idle <= '0;
        end else if (w_tick) begin
            r_idle <= r_idle + IDLE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hours   <= '0;
            r_minutes <= '0;
            r_seconds <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    // Entering SET_HH swallows a coincident tick and zeroes seconds
                    if (btn_mode) begin
                        r_seconds <= '0;
                    end else if (w_tick) begin
                        if (r_seconds == 6'd59) begin
                            r_seconds <= '0;
                            if (r_minutes == 6'd59) begin
                                r_minutes <= '0;
                                r_hours   <= inc_mod24(r_hours);
                            end else begin
                                r_minutes <= r_minutes + 6'd1;
                            end
                        end else begin
                            r_seconds <= r_seconds + 6'd1;
                        end
                    end
                end
                ST_SET_HH: begin
                    if (w_inc_ok) begin
                        r_hours <= inc_mod24(r_hours);
                    end
                end
                ST_SET_MM: begin
                    if (w_inc_ok) begin
                        r_minutes <= inc_mod60(r_minutes);
                    end
                end
                default: begin
                    r_seconds <= r_seconds;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hide_hh  <= 1'b0;
            r_hide_mm  <= 1'b0;
            r_sec_tick <= 1'b0;
        end else begin
            r_hide_hh  <= (r_state == ST_SET_HH) && blink;
            r_hide_mm  <= (r_state == ST_SET_MM) && blink;
            r_sec_tick <= (r_state == ST_RUN) && w_tick && !btn_mode;
        end
    end

    assign hours    = r_hours;
    assign minutes  = r_minutes;
    assign seconds  = r_seconds;
    assign mode     = r_state;
    assign hide_hh  = r_hide_hh;
    assign hide_mm  = r_hide_mm;
    assign sec_tick = r_sec_tick;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Scoreboard bench for clock_mode_ctrl: directed stimulus queues hand-computed
// expectations per cycle; an independent monitor pops and compares them.
module tb_clock_mode_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_mode;
    logic       btn_inc;
    logic       blink;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [1:0] mode;
    logic       hide_hh;
    logic       hide_mm;
    logic       sec_tick;

    clock_mode_ctrl #(
        .TICK_MAX (4),
        .TIMEOUT_S(3)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .btn_mode(btn_mode),
        .btn_inc (btn_inc),
        .blink   (blink),
        .hours   (hours),
        .minutes (minutes),
        .seconds (seconds),
        .mode    (mode),
        .hide_hh (hide_hh),
        .hide_mm (hide_mm),
        .sec_tick(sec_tick)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        string      name;
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic [1:0] md;
        logic       hh;
        logic       hm;
        logic       st;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input string fld, input logic [7:0] act, input logic [7:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s: got %0d expected %0d at t=%0t", name, fld, act, req, $time);
        end
    endtask

    task automatic compare(input exp_t e);
        chk(e.name, "hours",    8'(hours),    8'(e.h));
        chk(e.name, "minutes",  8'(minutes),  8'(e.m));
        chk(e.name, "seconds",  8'(seconds),  8'(e.s));
        chk(e.name, "mode",     8'(mode),     8'(e.md));
        chk(e.name, "hide_hh",  8'(hide_hh),  8'(e.hh));
        chk(e.name, "hide_mm",  8'(hide_mm),  8'(e.hm));
        chk(e.name, "sec_tick", 8'(sec_tick), 8'(e.st));
    endtask

    // cyc of -1 marks an expectation tied to the asynchronous reset edge
    task automatic push(input string name, input int h, input int m, input int s, input int md,
                        input int hh, input int hm, input int st, input bit async_chk);
        exp_t e;
        e.cyc  = async_chk ? -1 : cyc + 1;
        e.name = name;
        e.h    = 5'(h);
        e.m    = 6'(m);
        e.s    = 6'(s);
        e.md   = 2'(md);
        e.hh   = hh[0];
        e.hm   = hm[0];
        e.st   = st[0];
        q.push_back(e);
    endtask

    task automatic step(input logic bm, input logic bi, input logic bl);
        btn_mode = bm;
        btn_inc  = bi;
        blink    = bl;
        @(negedge clk);
    endtask

    task automatic t(input logic bm, input logic bi, input logic bl, input string name,
                     input int h, input int m, input int s, input int md,
                     input int hh, input int hm, input int st);
        push(name, h, m, s, md, hh, hm, st, 1'b0);
        step(bm, bi, bl);
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            #1;
            while (q.size() > 0 && (q[0].cyc == -1 || q[0].cyc <= cyc)) begin
                compare(q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected end before t=%0t", $time);
        $fatal(1);
    end

    initial begin
        reset    = 1'b0;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        blink    = 1'b0;
        repeat (2) @(negedge clk);
        t(0, 0, 0, "rst_hold", 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;

        for (int i = 1; i <= 11; i++)
            t(0, 0, 0, "run_start", 0, 0, (i <= 8) ? i / 4 : 2, 0, 0, 0, (i % 4 == 0 && i <= 8) ? 1 : 0);
        // tick coincides with mode press: tick dropped, seconds cleared
        t(1, 0, 0, "tick_vs_mode", 0, 0, 0, 1, 0, 0, 0);

        for (int k = 1; k <= 25; k++)
            t(0, 1, 0, "set_hh_inc", k % 24, 0, 0, 1, 0, 0, 0);
        t(0, 0, 1, "blink_hh", 1, 0, 0, 1, 1, 0, 0);
        t(0, 0, 0, "blink_hh", 1, 0, 0, 1, 0, 0, 0);
        t(0, 0, 1, "blink_hh", 1, 0, 0, 1, 1, 0, 0);
        t(0, 0, 0, "blink_hh", 1, 0, 0, 1, 0, 0, 0);
        t(1, 0, 0, "to_set_mm", 1, 0, 0, 2, 0, 0, 0);

        for (int k = 1; k <= 61; k++)
            t(0, 1, 0, "set_mm_inc", 1, k % 60, 0, 2, 0, 0, 0);
        t(0, 0, 1, "blink_mm", 1, 1, 0, 2, 0, 1, 0);
        t(0, 0, 0, "blink_mm", 1, 1, 0, 2, 0, 0, 0);
        t(0, 0, 1, "blink_mm", 1, 1, 0, 2, 0, 1, 0);
        t(0, 0, 0, "blink_mm", 1, 1, 0, 2, 0, 0, 0);
        t(0, 0, 0, "mm_wait",  1, 1, 0, 2, 0, 0, 0);
        t(1, 0, 0, "to_run",   1, 1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 3; i++)
            t(0, 0, 1, "run_blank", 1, 1, 0, 0, 0, 0, 0);
        t(0, 0, 0, "first_sec", 1, 1, 1, 0, 0, 0, 1);

        t(1, 0, 0, "to_hh_tmo", 1, 1, 0, 1, 0, 0, 0);
        t(0, 1, 0, "inc_tmo",   2, 1, 0, 1, 0, 0, 0);
        for (int i = 1; i <= 9; i++)
            t(0, 0, 0, "idle_hh", 2, 1, 0, 1, 0, 0, 0);
        t(0, 0, 0, "timeout", 2, 1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 3; i++)
            t(0, 0, 0, "after_tmo", 2, 1, 0, 0, 0, 0, 0);
        t(0, 0, 0, "after_tmo_sec", 2, 1, 1, 0, 0, 0, 1);

        t(1, 0, 0, "to_hh_prio", 2, 1, 0, 1, 0, 0, 0);
        t(1, 1, 0, "mode_wins",  2, 1, 0, 2, 0, 0, 0);
        for (int i = 1; i <= 9; i++)
            t(0, 0, 0, "idle_mm", 2, 1, 0, 2, 0, 0, 0);
        // button in the timeout cycle keeps SET_MM
        t(0, 1, 0, "btn_vs_tmo", 2, 2, 0, 2, 0, 0, 0);
        for (int k = 1; k <= 35; k++)
            t(0, 1, 0, "to_37", 2, 2 + k, 0, 2, 0, 0, 0);

        push("async_rst", 0, 0, 0, 0, 0, 0, 0, 1'b1);
        #2;
        reset = 1'b0;
        @(negedge clk);
        t(0, 0, 0, "rst_hold2", 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        for (int i = 1; i <= 4; i++)
            t(0, 0, 0, "rerun", 0, 0, i / 4, 0, 0, 0, (i == 4) ? 1 : 0);

        t(1, 0, 0, "pre_hh", 0, 0, 0, 1, 0, 0, 0);
        for (int k = 1; k <= 23; k++)
            t(0, 1, 0, "pre_hh_inc", k, 0, 0, 1, 0, 0, 0);
        t(1, 0, 0, "pre_mm", 23, 0, 0, 2, 0, 0, 0);
        for (int k = 1; k <= 59; k++)
            t(0, 1, 0, "pre_mm_inc", 23, k, 0, 2, 0, 0, 0);
        t(1, 0, 0, "pre_run", 23, 59, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 239; i++)
            t(0, 0, 0, "roll_run", 23, 59, (i <= 236) ? i / 4 : 59, 0, 0, 0, (i % 4 == 0) ? 1 : 0);
        t(0, 0, 0, "rollover", 0, 0, 0, 0, 0, 0, 1);
        t(0, 0, 0, "post_roll", 0, 0, 0, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
